imem_boot_loader: RTL

IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

---
 rtl/imem_boot_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// UART boot loader: receives a framed image, writes it word-by-word into IMEM, verifies an XOR
// checksum, then hands the IMEM address port to the CPU fetch path.
module imem_boot_loader #(
  parameter int unsigned SIZE        = 2048,
  parameter int unsigned TIMEOUT_CYC = 100000,
  localparam int unsigned AW         = $clog2(SIZE)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx_valid,
  input  logic [7:0]    i_rx_data,
  input  logic          i_boot_req,
  input  logic [31:0]   i_pc,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_cpu_hold,
  output logic          o_done,
  output logic          o_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [15:0]     r_len;
  logic [AW-1:0]   r_idx;
  logic [1:0]      r_bcnt;
  logic [7:0]      r_csum;
  logic [23:0]     r_asm;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic [TW-1:0]   r_tmo;

  logic [15:0]     w_len_new;
  logic            w_last_word;
  logic            w_active;
  logic            w_tmo_hit;
  logic            w_unused_pc;

  assign w_len_new   = {i_rx_data, r_len[7:0]};
  assign w_last_word = (32'(r_idx) + 32'd1) == 32'(r_len);
  assign w_active    = (r_state == StLen0) || (r_state == StLen1) ||
                       (r_state == StData) || (r_state == StCsum);
  assign w_tmo_hit   = w_active && !i_rx_valid && (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_unused_pc = ^{i_pc[31:AW+2], i_pc[1:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_rx_valid && (i_rx_data == SyncByte)) w_state_next = StLen0;
      end
      StLen0: begin
        if (i_rx_valid) w_state_next = StLen1;
      end
      StLen1: begin
        if (i_rx_valid) begin
          if ((w_len_new == 16'd0) || (32'(w_len_new) > SIZE)) w_state_next = StErr;
          else                                                  w_state_next = StData;
        end
      end
      StData: begin
        if (i_rx_valid && (r_bcnt == 2'd3) && w_last_word) w_state_next = StCsum;
      end
      StCsum: begin
        if (i_rx_valid) w_state_next = (i_rx_data == r_csum) ? StDone : StErr;
      end
      StDone: begin
        // A byte arriving alongside the boot request is dropped, even a sync byte.
        if (i_boot_req) w_state_next = StIdle;
      end
      StErr: begin
        if (i_rx_valid && (i_rx_data == SyncByte)) w_state_next = StLen0;
      end
      default: w_state_next = StIdle;
    endcase
    if (w_tmo_hit) w_state_next = StErr;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_len   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_csum  <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_we <= 1'b0;
      // Index advances after the write cycle and saturates at the last word of the frame.
      if (r_we && ((32'(r_idx) + 32'd1) < 32'(r_len))) r_idx <= r_idx + AW'(1);

      if (w_active && !i_rx_valid && !w_tmo_hit) r_tmo <= r_tmo + TW'(1);
      else                                        r_tmo <= '0;

      if (i_rx_valid) begin
        unique case (r_state)
          StLen0: r_len[7:0] <= i_rx_data;
          StLen1: begin
            r_len  <= w_len_new;
            r_idx  <= '0;
            r_bcnt <= '0;
            r_csum <= '0;
          end
          StData: begin
            r_csum <= r_csum ^ i_rx_data;
            r_bcnt <= r_bcnt + 2'd1;
            unique case (r_bcnt)
              2'd0: r_asm[7:0]   <= i_rx_data;
              2'd1: r_asm[15:8]  <= i_rx_data;
              2'd2: r_asm[23:16] <= i_rx_data;
              default: begin
                r_wdata <= {i_rx_data, r_asm};
                r_we    <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_mem_we    = r_we;
    o_mem_wdata = r_wdata;
    o_done      = (r_state == StDone);
    o_err       = (r_state == StErr);
    o_cpu_hold  = (r_state != StDone);
    o_mem_addr  = (r_state == StDone) ? i_pc[AW+1:2] : r_idx;
  end

endmodule
